// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control-unit to datapath signal bundle
//
// Purpose: groups the opcode/memory-ready inputs and every datapath
// enable/select produced by multicycle_control_unit.
// Modports:
//   master - the control unit: consumes opcode/mem_ready, drives controls.
//   slave  - the datapath/memory side: drives opcode/mem_ready, consumes controls.
interface multicycle_control_unit_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       reg_dst;
  logic       mem_2_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
           i_or_d, reg_dst, mem_2_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
           i_or_d, reg_dst, mem_2_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS control FSM with memory-ready stalls
//
// Purpose: steps each instruction through FETCH/DECODE/... one datapath step
// per clock and drives every mux select and write enable of the datapath.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset; also gates all control outputs to 0
//   ctl   - master modport: opcode/mem_ready in, enables/selects/state out
// Parameter:
//   MEM_WAIT_EN - 1: memory states wait for mem_ready; 0: mem_ready ignored
module multicycle_control_unit #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.master   ctl
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_ADDI_EX   = 4'd9;
  localparam logic [3:0] S_ADDI_WB   = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  logic [3:0] state_q, state_d;
  logic       rdy;

  // Ungated control decodes; forced to 0 below while reset is asserted.
  logic       pc_write_c, pc_write_cond_c, ir_write_c, reg_write_c;
  logic       mem_read_c, mem_write_c, i_or_d_c, reg_dst_c, mem_2_reg_c;
  logic       alu_src_a_c, illegal_op_c, instr_done_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

  assign rdy = ctl.mem_ready | ~MEM_WAIT_EN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (ctl.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R:         state_d = S_EXECUTE;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only LW and SW reach MEM_ADR, so a single compare picks the path.
      S_MEM_ADR:   state_d = (ctl.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (rdy) state_d = S_MEM_WB;
      S_MEM_WRITE: if (rdy) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_ALU_WB, S_ADDI_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    ir_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    i_or_d_c        = 1'b0;
    reg_dst_c       = 1'b0;
    mem_2_reg_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    illegal_op_c    = 1'b0;
    instr_done_c    = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 2'b00;
    pc_source_c     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        // IR and PC only load once the instruction word is actually back.
        ir_write_c  = rdy;
        pc_write_c  = rdy;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (ctl.opcode)
          OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: illegal_op_c = 1'b0;
          default:                                   illegal_op_c = 1'b1;
        endcase
      end
      S_MEM_ADR, S_ADDI_EX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_c  = 1'b1;
        i_or_d_c     = 1'b1;
        instr_done_c = rdy;
      end
      S_MEM_WB: begin
        mem_2_reg_c  = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
      end
      S_ALU_WB: begin
        reg_dst_c    = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
        instr_done_c    = 1'b1;
      end
      S_JUMP: begin
        pc_write_c   = 1'b1;
        pc_source_c  = 2'b10;
        instr_done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Combinational reset gating: a reset mid-instruction kills strobes in the
  // same cycle, so no partial write reaches memory or the register file.
  assign ctl.pc_write      = pc_write_c      & rst_n;
  assign ctl.pc_write_cond = pc_write_cond_c & rst_n;
  assign ctl.ir_write      = ir_write_c      & rst_n;
  assign ctl.reg_write     = reg_write_c     & rst_n;
  assign ctl.mem_read      = mem_read_c      & rst_n;
  assign ctl.mem_write     = mem_write_c     & rst_n;
  assign ctl.i_or_d        = i_or_d_c        & rst_n;
  assign ctl.reg_dst       = reg_dst_c       & rst_n;
  assign ctl.mem_2_reg     = mem_2_reg_c     & rst_n;
  assign ctl.alu_src_a     = alu_src_a_c     & rst_n;
  assign ctl.illegal_op    = illegal_op_c    & rst_n;
  assign ctl.instr_done    = instr_done_c    & rst_n;
  assign ctl.alu_src_b     = alu_src_b_c     & {2{rst_n}};
  assign ctl.alu_op        = alu_op_c        & {2{rst_n}};
  assign ctl.pc_source     = pc_source_c     & {2{rst_n}};
  assign ctl.state         = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_nw;
  always #5 clk = ~clk;

  multicycle_control_unit_if bus ();
  multicycle_control_unit_if bus_nw ();

  multicycle_control_unit #(.MEM_WAIT_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ctl(bus)
  );

  multicycle_control_unit #(.MEM_WAIT_EN(1'b0)) u_dut_nw (
    .clk(clk), .rst_n(rst_nw), .ctl(bus_nw)
  );

  // {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, i_or_d,
  //  reg_dst, mem_2_reg, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2],
  //  illegal_op, instr_done}
  logic [17:0] outs, outs_nw;
  assign outs = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write,
                 bus.mem_read, bus.mem_write, bus.i_or_d, bus.reg_dst,
                 bus.mem_2_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                 bus.pc_source, bus.illegal_op, bus.instr_done};
  assign outs_nw = {bus_nw.pc_write, bus_nw.pc_write_cond, bus_nw.ir_write,
                    bus_nw.reg_write, bus_nw.mem_read, bus_nw.mem_write,
                    bus_nw.i_or_d, bus_nw.reg_dst, bus_nw.mem_2_reg,
                    bus_nw.alu_src_a, bus_nw.alu_src_b, bus_nw.alu_op,
                    bus_nw.pc_source, bus_nw.illegal_op, bus_nw.instr_done};

  localparam logic [17:0] O_NONE   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_FETCH  = 18'b1_0_1_0_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] O_FSTALL = 18'b0_0_0_0_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] O_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] O_DECILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [17:0] O_ADR    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] O_MRD    = 18'b0_0_0_0_1_0_1_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_MWB    = 18'b0_0_0_1_0_0_0_0_1_0_00_00_00_0_1;
  localparam logic [17:0] O_MWR    = 18'b0_0_0_0_0_1_1_0_0_0_00_00_00_0_1;
  localparam logic [17:0] O_MWRST  = 18'b0_0_0_0_0_1_1_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_EXE    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] O_AWB    = 18'b0_0_0_1_0_0_0_1_0_0_00_00_00_0_1;
  localparam logic [17:0] O_IWB    = 18'b0_0_0_1_0_0_0_0_0_0_00_00_00_0_1;
  localparam logic [17:0] O_BR     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
  localparam logic [17:0] O_JMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_1;

  typedef struct {
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [17:0] exp_outs;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [17:0] o);
    vec_t v;
    v.opcode = op; v.mem_ready = mr; v.exp_state = st; v.exp_outs = o;
    vecs.push_back(v);
  endtask

  logic [3:0]  nw_st[6];
  logic [17:0] nw_o[6];

  initial begin
    // R-type: 0,1,6,7 (mem_ready low outside memory states must not matter)
    add(6'h00, 1'b1, 4'd0, O_FETCH);
    add(6'h00, 1'b0, 4'd1, O_DEC);
    add(6'h00, 1'b0, 4'd6, O_EXE);
    add(6'h00, 1'b0, 4'd7, O_AWB);
    // ADDI: 0,1,9,10
    add(6'h08, 1'b1, 4'd0, O_FETCH);
    add(6'h08, 1'b1, 4'd1, O_DEC);
    add(6'h08, 1'b1, 4'd9, O_ADR);
    add(6'h08, 1'b1, 4'd10, O_IWB);
    // LW with two stalled MEM_READ cycles: 0,1,2,3,3,3,4
    add(6'h23, 1'b1, 4'd0, O_FETCH);
    add(6'h23, 1'b1, 4'd1, O_DEC);
    add(6'h23, 1'b0, 4'd2, O_ADR);
    add(6'h23, 1'b0, 4'd3, O_MRD);
    add(6'h23, 1'b0, 4'd3, O_MRD);
    add(6'h23, 1'b1, 4'd3, O_MRD);
    add(6'h23, 1'b0, 4'd4, O_MWB);
    // SW with one FETCH stall and one MEM_WRITE stall
    add(6'h2B, 1'b0, 4'd0, O_FSTALL);
    add(6'h2B, 1'b1, 4'd0, O_FETCH);
    add(6'h2B, 1'b1, 4'd1, O_DEC);
    add(6'h2B, 1'b1, 4'd2, O_ADR);
    add(6'h2B, 1'b0, 4'd5, O_MWRST);
    add(6'h2B, 1'b1, 4'd5, O_MWR);
    // BEQ then J back-to-back
    add(6'h04, 1'b1, 4'd0, O_FETCH);
    add(6'h04, 1'b1, 4'd1, O_DEC);
    add(6'h04, 1'b1, 4'd8, O_BR);
    add(6'h02, 1'b1, 4'd0, O_FETCH);
    add(6'h02, 1'b1, 4'd1, O_DEC);
    add(6'h02, 1'b1, 4'd11, O_JMP);
    // Illegal opcode: DECODE flags it, straight back to FETCH
    add(6'h3F, 1'b1, 4'd0, O_FETCH);
    add(6'h3F, 1'b1, 4'd1, O_DECILL);
    add(6'h00, 1'b0, 4'd0, O_FSTALL);

    nw_st[0] = 4'd0; nw_o[0] = O_FETCH;
    nw_st[1] = 4'd1; nw_o[1] = O_DEC;
    nw_st[2] = 4'd2; nw_o[2] = O_ADR;
    nw_st[3] = 4'd3; nw_o[3] = O_MRD;
    nw_st[4] = 4'd4; nw_o[4] = O_MWB;
    nw_st[5] = 4'd0; nw_o[5] = O_FETCH;

    // Reset with LW opcode and memory ready: everything must stay quiet.
    rst_n = 1'b0; rst_nw = 1'b0;
    bus.opcode = 6'h23; bus.mem_ready = 1'b1;
    bus_nw.opcode = 6'h23; bus_nw.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {28'd0, bus.state}, 32'd0);
    chk("reset_outs", {14'd0, outs}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.opcode    = vecs[i].opcode;
      bus.mem_ready = vecs[i].mem_ready;
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), {28'd0, bus.state}, {28'd0, vecs[i].exp_state});
      chk($sformatf("vec%0d_outs", i), {14'd0, outs}, {14'd0, vecs[i].exp_outs});
      @(posedge clk); #1;
    end

    // Reset while a SW is stalled in MEM_WRITE drops mem_write immediately.
    bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_stall_state", {28'd0, bus.state}, 32'd5);
    chk("sw_stall_mem_write", {31'd0, bus.mem_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("abort_state", {28'd0, bus.state}, 32'd0);
    chk("abort_outs", {14'd0, outs}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; bus.opcode = 6'h00; bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("restart_state", {28'd0, bus.state}, 32'd0);
    chk("restart_outs", {14'd0, outs}, {14'd0, O_FETCH});

    // MEM_WAIT_EN=0 with mem_ready tied low: LW still completes in 5 cycles.
    @(posedge clk); #1;
    rst_nw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("nowait%0d_state", i), {28'd0, bus_nw.state}, {28'd0, nw_st[i]});
      chk($sformatf("nowait%0d_outs", i), {14'd0, outs_nw}, {14'd0, nw_o[i]});
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
